// File: rtl/sha2_blk_sequencer.sv
// Ping-pong block buffer and sequencer in front of sha2_core.
// The host fills one buffer while the core hashes the other. Each committed
// block is streamed into the core one word per cycle, and then the core is
// started. The core's H state is reloaded only for the first block of a message.
module sha2_blk_sequencer #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned WORDS  = 16,
  parameter int unsigned ADDR_W = $clog2(WORDS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_abort,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_blk_valid,
  input  logic              i_blk_last,
  output logic              o_blk_ready,
  output logic              o_core_init,
  output logic              o_core_load,
  output logic [WIDTH-1:0]  o_core_data,
  output logic              o_core_start,
  input  logic              i_core_end_op,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WORDS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [WIDTH-1:0] buf_mem [0:1][0:WORDS-1];

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic [1:0]       blk_last_q;
  logic [1:0]       blk_last_nxt;
  logic             wp;
  logic             rp;
  logic             first_blk;
  logic             ovf_q;
  logic             load_q;
  logic [WIDTH-1:0] rd_q;

  logic             ready;
  logic             kill;
  logic             commit_ok;
  logic             wr_ok;
  logic             ovf_hit;
  logic             release_blk;
  logic             rd_en;
  logic [ADDR_W-1:0] rd_addr;

  assign ready       = !full[wp];
  assign kill        = i_rst || i_abort;
  assign commit_ok   = i_blk_valid && ready;
  assign wr_ok       = i_wr_en && ready && !kill;
  assign ovf_hit     = (i_wr_en || i_blk_valid) && !ready;
  assign release_blk = (state == S_DONE);
  assign rd_en       = (state == S_LOAD) && (cnt < CNT_END);
  assign rd_addr     = cnt[ADDR_W-1:0];

  // Next buffer flags; a commit and a release never target the same buffer
  // because a commit needs full[wp]=0 while a release needs full[rp]=1.
  always_comb begin
    full_nxt     = full;
    blk_last_nxt = blk_last_q;
    if (release_blk) begin
      full_nxt[rp] = 1'b0;
    end
    if (commit_ok) begin
      full_nxt[wp]     = 1'b1;
      blk_last_nxt[wp] = i_blk_last;
    end
  end

  // Host writes into the current write buffer (storage is not reset).
  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      buf_mem[wp][i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port; it directly forms the core load stream.
  always_ff @(posedge i_clk) begin
    if (kill) begin
      load_q <= 1'b0;
      rd_q   <= '0;
    end else begin
      load_q <= rd_en;
      rd_q   <= rd_en ? buf_mem[rp][rd_addr] : '0;
    end
  end

  // Buffer bookkeeping, overflow flag and block sequencing FSM.
  always_ff @(posedge i_clk) begin
    if (kill) begin
      state      <= S_IDLE;
      cnt        <= '0;
      full       <= '0;
      blk_last_q <= '0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      first_blk  <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      full       <= full_nxt;
      blk_last_q <= blk_last_nxt;
      if (commit_ok) begin
        wp <= ~wp;
      end
      if (ovf_hit) begin
        ovf_q <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (full[rp]) begin
            cnt   <= '0;
            state <= first_blk ? S_INIT : S_LOAD;
          end
        end
        S_INIT: begin
          first_blk <= 1'b0;
          state     <= S_LOAD;
        end
        S_LOAD: begin
          if (cnt == CNT_END) begin
            state <= S_RUN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (i_core_end_op) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          rp <= ~rp;
          if (blk_last_q[rp]) begin
            first_blk <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_blk_ready  = ready;
  assign o_core_init  = (state == S_INIT);
  assign o_core_load  = load_q;
  assign o_core_data  = rd_q;
  assign o_core_start = (state == S_RUN);
  assign o_busy       = (state != S_IDLE) || (|full);
  assign o_done       = (state == S_DONE) && blk_last_q[rp];
  assign o_ovf        = ovf_q;

endmodule

// File: tb/tb_sha2_blk_sequencer.sv
// Bench for sha2_blk_sequencer: a 64x16 instance under directed and random
// traffic, plus a 32x32 instance for the wide-block window and the same-cycle
// commit/release case.
module tb_sha2_blk_sequencer;

  localparam int EV_INIT = 1;
  localparam int EV_BLK  = 2;
  localparam int EV_DONE = 3;

  logic clk;
  logic rst;

  // instance A: WIDTH=64, WORDS=16
  logic        a_abort, a_wr_en, a_blk_valid, a_blk_last;
  logic [3:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_blk_ready, a_core_init, a_core_load, a_core_start;
  logic [63:0] a_core_data;
  logic        a_busy, a_done, a_ovf;
  logic        emu_end, man_end, stall;

  // instance B: WIDTH=32, WORDS=32
  logic        b_abort, b_wr_en, b_blk_valid, b_blk_last, b_end_op;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_blk_ready, b_core_init, b_core_load, b_core_start;
  logic [31:0] b_core_data;
  logic        b_busy, b_done, b_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model for A: two alternating buffers and expected streams
  logic [63:0] mbuf [2][16];
  bit          mwp    = 1'b0;
  bit          m_open = 1'b0;
  logic [63:0] exp_words[$];
  int          exp_ev[$];
  int          exp_runs[$];

  // observed streams for A
  logic [63:0] got_words[$];
  int          got_ev[$];
  int          got_runs[$];
  int          fall_q[$];
  int          rise_q[$];
  int          cyc = 0;

  // B expectations and observations
  logic [31:0] b_exp[$];
  logic [31:0] b_got[$];
  int          b_runs[$];
  int          b_init_cnt = 0;
  int          b_done_cnt = 0;

  sha2_blk_sequencer #(.WIDTH(64), .WORDS(16)) u_dut_a (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_abort       (a_abort),
    .i_wr_en       (a_wr_en),
    .i_wr_addr     (a_wr_addr),
    .i_wr_data     (a_wr_data),
    .i_blk_valid   (a_blk_valid),
    .i_blk_last    (a_blk_last),
    .o_blk_ready   (a_blk_ready),
    .o_core_init   (a_core_init),
    .o_core_load   (a_core_load),
    .o_core_data   (a_core_data),
    .o_core_start  (a_core_start),
    .i_core_end_op (emu_end | man_end),
    .o_busy        (a_busy),
    .o_done        (a_done),
    .o_ovf         (a_ovf)
  );

  sha2_blk_sequencer #(.WIDTH(32), .WORDS(32)) u_dut_b (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_abort       (b_abort),
    .i_wr_en       (b_wr_en),
    .i_wr_addr     (b_wr_addr),
    .i_wr_data     (b_wr_data),
    .i_blk_valid   (b_blk_valid),
    .i_blk_last    (b_blk_last),
    .o_blk_ready   (b_blk_ready),
    .o_core_init   (b_core_init),
    .o_core_load   (b_core_load),
    .o_core_data   (b_core_data),
    .o_core_start  (b_core_start),
    .i_core_end_op (b_end_op),
    .o_busy        (b_busy),
    .o_done        (b_done),
    .o_ovf         (b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor for A: records load words, run lengths and the event order
  initial begin
    bit pl = 1'b0;
    bit ps = 1'b0;
    int rl = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (a_core_load) begin
        if (!pl) begin
          got_ev.push_back(EV_BLK);
          rise_q.push_back(cyc);
        end
        got_words.push_back(a_core_data);
        rl++;
      end else if (pl) begin
        got_runs.push_back(rl);
        rl = 0;
      end
      if (a_core_init) got_ev.push_back(EV_INIT);
      if (a_done)      got_ev.push_back(EV_DONE);
      if (ps && !a_core_start) fall_q.push_back(cyc);
      pl = a_core_load;
      ps = a_core_start;
    end
  end

  // core stand-in for A: answers o_core_start after a random delay unless stalled
  initial begin
    int unsigned w = 0;
    emu_end = 1'b0;
    forever begin
      @(negedge clk);
      if (a_core_start && !stall && !emu_end) begin
        if (w == 0) emu_end = 1'b1;
        else w--;
      end else begin
        emu_end = 1'b0;
        w = $urandom_range(0, 4);
      end
    end
  end

  // monitor for B
  initial begin
    bit pl = 1'b0;
    int rl = 0;
    forever begin
      @(negedge clk);
      if (b_core_load) begin
        b_got.push_back(b_core_data);
        rl++;
      end else if (pl) begin
        b_runs.push_back(rl);
        rl = 0;
      end
      if (b_core_init) b_init_cnt++;
      if (b_done)      b_done_cnt++;
      pl = b_core_load;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // model: a committed block is the write buffer snapshot; messages bracket INIT/DONE
  task automatic m_commit(input bit last);
    for (int unsigned i = 0; i < 16; i++) exp_words.push_back(mbuf[mwp][i]);
    exp_runs.push_back(16);
    if (!m_open) exp_ev.push_back(EV_INIT);
    exp_ev.push_back(EV_BLK);
    if (last) exp_ev.push_back(EV_DONE);
    m_open = !last;
    mwp = ~mwp;
  endtask

  task automatic m_flush();
    mwp = 1'b0;
    m_open = 1'b0;
  endtask

  // mode 0: random full, 1: random partial, 2: word k = k, 3: skip word 0
  task automatic a_fill(input int mode);
    for (int unsigned i = 0; i < 16; i++) begin
      if (mode == 1 && $urandom_range(0, 3) == 0) continue;
      if (mode == 3 && i == 0) continue;
      a_wr_en   = 1'b1;
      a_wr_addr = 4'(i);
      a_wr_data = (mode == 2) ? 64'(i) : {$urandom, $urandom};
      mbuf[mwp][i] = a_wr_data;
      tick();
    end
    a_wr_en = 1'b0;
  endtask

  task automatic a_commit(input bit last, input bit with_wr);
    if (with_wr) begin
      a_wr_en   = 1'b1;
      a_wr_addr = 4'd15;
      a_wr_data = {$urandom, $urandom};
      mbuf[mwp][15] = a_wr_data;
    end
    a_blk_valid = 1'b1;
    a_blk_last  = last;
    tick();
    a_blk_valid = 1'b0;
    a_blk_last  = 1'b0;
    a_wr_en     = 1'b0;
    m_commit(last);
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 300 && !a_blk_ready; k++) tick();
    chk("ready_wait", a_blk_ready, 1);
  endtask

  task automatic wait_start();
    for (int k = 0; k < 100 && !a_core_start; k++) tick();
    chk("start_wait", a_core_start, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000 && a_busy; k++) tick();
    chk("idle_wait", a_busy, 0);
  endtask

  task automatic meas_lat(output int k);
    k = 0;
    while (!a_core_load && k < 20) begin
      tick();
      k++;
    end
  endtask

  task automatic b_fill();
    for (int unsigned i = 0; i < 32; i++) begin
      b_wr_en   = 1'b1;
      b_wr_addr = 5'(i);
      b_wr_data = $urandom;
      b_exp.push_back(b_wr_data);
      tick();
    end
    b_wr_en = 1'b0;
  endtask

  initial begin
    int lat;
    int f0;
    rst = 1'b1; stall = 1'b0; man_end = 1'b0;
    a_abort = 1'b0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
    a_blk_valid = 1'b0; a_blk_last = 1'b0;
    b_abort = 1'b0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    b_blk_valid = 1'b0; b_blk_last = 1'b0; b_end_op = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_ready", a_blk_ready, 1);
    chk("rst_init",  a_core_init, 0);
    chk("rst_load",  a_core_load, 0);
    chk("rst_data",  a_core_data, 0);
    chk("rst_start", a_core_start, 0);
    chk("rst_busy",  a_busy, 0);
    chk("rst_done",  a_done, 0);
    chk("rst_ovf",   a_ovf, 0);
    chk("rst_b_ready", b_blk_ready, 1);

    // single block, words 0..15 = k
    a_fill(2);
    a_commit(1'b1, 1'b0);
    meas_lat(lat);
    chk("lat_with_init", lat, 3);
    wait_idle();
    chk("one_ready", a_blk_ready, 1);
    chk("one_busy", a_busy, 0);

    // two-block message, second block filled while the first is in RUN
    stall = 1'b1;
    wait_ready(); a_fill(0); a_commit(1'b0, 1'b0);
    wait_start();
    a_fill(0); a_commit(1'b1, 1'b0);
    repeat (3) tick();
    stall = 1'b0;
    wait_idle();
    chk("gap_done_to_load", rise_q[$] - fall_q[$-1], 3);

    // continuation block committed while idle: no init, shorter latency
    wait_ready(); a_fill(0); a_commit(1'b0, 1'b0);
    wait_idle();
    a_fill(0); a_commit(1'b1, 1'b0);
    meas_lat(lat);
    chk("lat_no_init", lat, 2);
    wait_idle();

    // overflow with the core stalled in RUN
    stall = 1'b1;
    wait_ready(); a_fill(0); a_commit(1'b0, 1'b0);
    wait_start();
    a_fill(0); a_commit(1'b1, 1'b0);
    chk("ovf_not_ready", a_blk_ready, 0);
    chk("ovf_before", a_ovf, 0);
    a_wr_en = 1'b1; a_wr_addr = 4'd0; a_wr_data = 64'hDEAD_BEEF_0BAD_F00D;
    a_blk_valid = 1'b1; a_blk_last = 1'b1;
    tick();
    a_wr_en = 1'b0; a_blk_valid = 1'b0; a_blk_last = 1'b0;
    chk("ovf_set", a_ovf, 1);
    repeat (4) tick();
    chk("ovf_sticky", a_ovf, 1);
    stall = 1'b0;
    wait_idle();
    wait_ready(); a_fill(3); a_commit(1'b1, 1'b0);
    wait_idle();
    chk("ovf_sticky_end", a_ovf, 1);

    // abort in LOAD with cnt=7
    wait_ready(); a_fill(0); a_commit(1'b1, 1'b0);
    for (int k = 0; k < 50 && !a_core_load; k++) tick();
    chk("abort_load_seen", a_core_load, 1);
    repeat (6) tick();
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("abort_load", a_core_load, 0);
    chk("abort_ready", a_blk_ready, 1);
    chk("abort_busy", a_busy, 0);
    chk("abort_ovf", a_ovf, 0);
    void'(exp_ev.pop_back());
    repeat (9) void'(exp_words.pop_back());
    void'(exp_runs.pop_back());
    exp_runs.push_back(7);
    m_flush();
    repeat (5) tick();
    a_fill(0); a_commit(1'b1, 1'b0);
    meas_lat(lat);
    chk("abort_next_lat", lat, 3);
    wait_idle();

    // reset mid-RUN, then a spurious end_op
    stall = 1'b1;
    wait_ready(); a_fill(0); a_commit(1'b1, 1'b0);
    wait_start();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_ready", a_blk_ready, 1);
    chk("mrst_init",  a_core_init, 0);
    chk("mrst_load",  a_core_load, 0);
    chk("mrst_data",  a_core_data, 0);
    chk("mrst_start", a_core_start, 0);
    chk("mrst_busy",  a_busy, 0);
    chk("mrst_done",  a_done, 0);
    chk("mrst_ovf",   a_ovf, 0);
    void'(exp_ev.pop_back());
    m_flush();
    man_end = 1'b1;
    tick();
    man_end = 1'b0;
    repeat (3) tick();
    chk("spur_busy", a_busy, 0);
    chk("spur_start", a_core_start, 0);
    stall = 1'b0;

    // random multi-block messages, partial fills, back-to-back commits
    for (int m = 0; m < 8; m++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        wait_ready();
        a_fill($urandom_range(0, 1));
        repeat ($urandom_range(0, 3)) tick();
        a_commit(b == nb - 1, 1'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(0, 20)) tick();
    end
    wait_idle();
    repeat (3) tick();
    chk("rand_ovf", a_ovf, 0);

    // compare observed streams with the model
    chk("words_n", got_words.size(), exp_words.size());
    for (int i = 0; i < got_words.size() && i < exp_words.size(); i++) begin
      f0 = n_fail;
      chk($sformatf("word%0d", i), got_words[i], exp_words[i]);
      if (n_fail != f0) break;
    end
    chk("events_n", got_ev.size(), exp_ev.size());
    for (int i = 0; i < got_ev.size() && i < exp_ev.size(); i++) begin
      f0 = n_fail;
      chk($sformatf("event%0d", i), got_ev[i], exp_ev[i]);
      if (n_fail != f0) break;
    end
    chk("runs_n", got_runs.size(), exp_runs.size());
    for (int i = 0; i < got_runs.size() && i < exp_runs.size(); i++) begin
      f0 = n_fail;
      chk($sformatf("run%0d", i), got_runs[i], exp_runs[i]);
      if (n_fail != f0) break;
    end

    // B: 32-word window and commit in the same cycle as the DONE release
    b_fill();
    b_blk_valid = 1'b1; b_blk_last = 1'b0;
    tick();
    b_blk_valid = 1'b0;
    b_fill();
    for (int k = 0; k < 100 && !b_core_start; k++) tick();
    chk("b_run1", b_core_start, 1);
    b_end_op = 1'b1;
    tick();
    b_end_op = 1'b0;
    chk("b_in_done_start", b_core_start, 0);
    chk("b_in_done_busy", b_busy, 1);
    b_blk_valid = 1'b1; b_blk_last = 1'b1;
    tick();
    b_blk_valid = 1'b0; b_blk_last = 1'b0;
    chk("b_release_ready", b_blk_ready, 1);
    chk("b_commit_busy", b_busy, 1);
    for (int k = 0; k < 100 && !b_core_start; k++) tick();
    chk("b_run2", b_core_start, 1);
    b_end_op = 1'b1;
    tick();
    b_end_op = 1'b0;
    for (int k = 0; k < 20 && b_busy; k++) tick();
    chk("b_idle", b_busy, 0);
    chk("b_ovf", b_ovf, 0);
    chk("b_init_cnt", b_init_cnt, 1);
    chk("b_done_cnt", b_done_cnt, 1);
    chk("b_runs_n", b_runs.size(), 2);
    for (int i = 0; i < b_runs.size(); i++) chk($sformatf("b_run_len%0d", i), b_runs[i], 32);
    chk("b_words_n", b_got.size(), b_exp.size());
    for (int i = 0; i < b_got.size() && i < b_exp.size(); i++) begin
      f0 = n_fail;
      chk($sformatf("b_word%0d", i), b_got[i], b_exp[i]);
      if (n_fail != f0) break;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
